// File: rtl/bus_arbiter_reg.sv
// Registered common-bus controller: selects one of NSRC sources onto bus_data.
// Register sources complete in one cycle; memory uses a read handshake with a timeout.
module bus_arbiter_reg #(
    parameter int                 DATA_W      = 16,
    parameter int                 ADDR_W      = 12,
    parameter int                 NSRC        = 8,
    parameter int                 SEL_W       = 3,
    parameter int                 MEM_SEL     = 7,
    parameter logic [NSRC-1:0]    NARROW_MASK = 8'b0000_0110,
    parameter int                 TIMEOUT     = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req,
    input  logic [SEL_W-1:0]       sel,
    input  logic [NSRC*DATA_W-1:0] src_data,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_ack,
    input  logic                   err_clr,
    output logic                   req_ready,
    output logic                   mem_rd,
    output logic [DATA_W-1:0]      bus_data,
    output logic                   bus_valid,
    output logic [SEL_W-1:0]       bus_src,
    output logic                   err,
    output logic [1:0]             err_code
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] ADDR_MASK = {{(DATA_W-ADDR_W){1'b0}}, {ADDR_W{1'b1}}};
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [0:0] {IDLE, MEM_WAIT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               sel_legal;
    logic               sel_mem;
    logic [DATA_W-1:0]  src_word;

    // Handshake: a request is taken on any edge where req && req_ready; req while
    // req_ready=0 is dropped, and each completed transfer pulses bus_valid once.
    assign req_ready = (state == IDLE);

    always_comb begin
        sel_legal = (sel != '0) && (32'(sel) < NSRC);
        sel_mem   = (sel == SEL_W'(MEM_SEL));
        src_word  = src_data[sel*DATA_W +: DATA_W];
        if (NARROW_MASK[sel]) begin
            src_word = src_word & ADDR_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_rd    <= 1'b0;
            bus_data  <= '0;
            bus_valid <= 1'b0;
            bus_src   <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            bus_valid <= 1'b0;
            // Clear first so an error raised on the same edge overrides it.
            if (err_clr) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!sel_legal) begin
                            err      <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                        end else if (sel_mem) begin
                            mem_rd   <= 1'b1;
                            wait_cnt <= '0;
                            state    <= MEM_WAIT;
                        end else begin
                            bus_data  <= src_word;
                            bus_src   <= sel;
                            bus_valid <= 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    // wait_cnt holds the number of ack-less cycles already spent.
                    if (mem_ack) begin
                        bus_data  <= mem_rdata;
                        bus_src   <= SEL_W'(MEM_SEL);
                        bus_valid <= 1'b1;
                        mem_rd    <= 1'b0;
                        state     <= IDLE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        mem_rd   <= 1'b0;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
